// File: rtl/regfile_pkg.sv
// Shared widths, register-file constants and FSM state encoding for the
// register-file write arbiter.
package regfile_pkg;

   localparam int unsigned DATA_W    = 64;
   localparam int unsigned ADDR_W    = 5;
   localparam int unsigned ZERO_REG  = 31;
   localparam int unsigned NUM_CLEAR = 31;
   localparam int unsigned CNT_W     = 5;

   typedef enum logic {
      ARB   = 1'b0,
      CLEAR = 1'b1
   } state_e;

endpackage

// File: rtl/regfile_wr_arb_rr_arb2.sv
// Two-way round-robin grant: a lone request wins outright, a tie goes to the
// requester that was not granted last (last=1 means B was granted last).
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = req;
      if (req == 2'b11) begin
         gnt = last ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/regfile_wr_arb.sv
// Register-file write-port arbiter: round-robin between ALU (A) and load unit
// (B) writebacks, plus a sequenced clear of X0..X30.
module regfile_wr_arb #(
   parameter int unsigned DATA_W = regfile_pkg::DATA_W,
   parameter int unsigned ADDR_W = regfile_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              a_valid,
   input  logic [ADDR_W-1:0] a_reg,
   input  logic [DATA_W-1:0] a_data,
   output logic              a_ready,
   input  logic              b_valid,
   input  logic [ADDR_W-1:0] b_reg,
   input  logic [DATA_W-1:0] b_data,
   output logic              b_ready,
   input  logic              clear_start,
   output logic              RegWrite,
   output logic [ADDR_W-1:0] WriteRegister,
   output logic [DATA_W-1:0] WriteData,
   output logic              busy,
   output logic              clear_done,
   output logic              dropped
);

   import regfile_pkg::*;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               last_q, last_d;
   logic               regwrite_q, regwrite_d;
   logic [ADDR_W-1:0]  wreg_q, wreg_d;
   logic [DATA_W-1:0]  wdata_q, wdata_d;
   logic               done_q, done_d;
   logic               drop_q, drop_d;

   logic [1:0]         gnt;
   logic               arb_en;
   logic               hs_a, hs_b;
   logic               clear_last;
   logic [ADDR_W-1:0]  hs_reg;
   logic [DATA_W-1:0]  hs_data;

   rr_arb2 u_rr (
      .req  ({b_valid, a_valid}),
      .last (last_q),
      .gnt  (gnt)
   );

   assign clear_last = (cnt_q == CNT_W'(NUM_CLEAR - 1));

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ARB;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ARB:     if (clear_start) state_d = CLEAR;
         CLEAR:   if (clear_last)  state_d = ARB;
         default: state_d = ARB;
      endcase
   end

   // FSM outputs
   always_comb begin
      arb_en  = (state_q == ARB) && !clear_start;
      a_ready = arb_en && gnt[0];
      b_ready = arb_en && gnt[1];
      busy    = (state_q == CLEAR);
   end

   assign hs_a    = a_valid && a_ready;
   assign hs_b    = b_valid && b_ready;
   assign hs_reg  = hs_b ? b_reg  : a_reg;
   assign hs_data = hs_b ? b_data : a_data;

   // The write port is registered; loading the clear counter value one edge
   // early keeps WriteRegister equal to the count during each CLEAR cycle.
   always_comb begin
      cnt_d      = '0;
      regwrite_d = 1'b0;
      wreg_d     = wreg_q;
      wdata_d    = wdata_q;
      drop_d     = 1'b0;
      done_d     = (state_q == CLEAR) && clear_last;
      last_d     = last_q;
      if (state_d == CLEAR) begin
         cnt_d      = (state_q == CLEAR) ? CNT_W'(cnt_q + CNT_W'(1)) : '0;
         regwrite_d = 1'b1;
         wreg_d     = ADDR_W'(cnt_d);
         wdata_d    = '0;
      end else if (hs_a || hs_b) begin
         last_d     = hs_b;
         drop_d     = (hs_reg == ADDR_W'(ZERO_REG));
         regwrite_d = !drop_d;
         wreg_d     = hs_reg;
         wdata_d    = hs_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q      <= '0;
         last_q     <= 1'b1;
         regwrite_q <= 1'b0;
         wreg_q     <= '0;
         wdata_q    <= '0;
         done_q     <= 1'b0;
         drop_q     <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         last_q     <= last_d;
         regwrite_q <= regwrite_d;
         wreg_q     <= wreg_d;
         wdata_q    <= wdata_d;
         done_q     <= done_d;
         drop_q     <= drop_d;
      end
   end

   assign RegWrite      = regwrite_q;
   assign WriteRegister = wreg_q;
   assign WriteData     = wdata_q;
   assign clear_done    = done_q;
   assign dropped       = drop_q;

endmodule

// File: doc/regfile_wr_arb.md
REGFILE_WR_ARB -- requirements
Module: regfile_wr_arb

Interface
REQ-001 Parameter DATA_W, default 64, SHALL set the width of the write data.
REQ-002 Parameter ADDR_W, default 5, SHALL set the width of the register index (32 registers).
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  in  1  SHALL be an asynchronous, active-high reset.
REQ-005 a_valid  in  1  SHALL mean requester A (ALU writeback) presents a write.
REQ-006 a_reg  in  ADDR_W, and a_data  in  DATA_W, SHALL carry A's target register and value.
REQ-007 a_ready  out  1  SHALL mean A's write is accepted this cycle.
REQ-008 b_valid, b_reg, b_data, b_ready SHALL mirror REQ-005..007 for requester B (load unit).
REQ-009 clear_start  in  1  SHALL be a single-cycle request to zero registers X0..X30.
REQ-010 RegWrite  out  1, WriteRegister  out  ADDR_W, and WriteData  out  DATA_W SHALL drive the register file write port.
REQ-011 busy  out  1  SHALL be high while a clear sequence runs.
REQ-012 clear_done  out  1  SHALL pulse for one cycle when a clear completes.
REQ-013 dropped  out  1  SHALL pulse for one cycle when an accepted write targets X31.

Function
REQ-014 The FSM SHALL have the states ARB and CLEAR; reset enters ARB.
REQ-015 A handshake SHALL occur when x_valid and x_ready are both high at a rising edge.
REQ-016 In ARB with clear_start low, if only one requester is valid, that requester's ready SHALL be high (combinational).
REQ-017 When both requesters are valid, ready SHALL go to the requester not granted last (round-robin); after reset, A SHALL win the first tie.
REQ-018 At most one ready SHALL be high per cycle; ready SHALL be low for any requester whose valid is low.
REQ-019 Only a completed handshake SHALL update the last-grant flop.
REQ-020 Write outputs SHALL be registered: a handshake at edge k SHALL drive RegWrite=1, WriteRegister=x_reg, WriteData=x_data in the cycle after k, giving 1-cycle latency.
REQ-021 A handshake with x_reg=31 SHALL be accepted with RegWrite=0 in the following cycle and dropped=1.
REQ-022 With no handshake and not in CLEAR, RegWrite SHALL be 0; WriteRegister and WriteData SHALL hold their last values.
REQ-023 clear_start high in ARB SHALL force both readys low that cycle and enter CLEAR at the next edge.
REQ-024 In CLEAR, a 5-bit counter starting at 0 SHALL drive RegWrite=1, WriteRegister=count, WriteData=0 each cycle, for 31 cycles (0..30).
REQ-025 After the count-30 write, the FSM SHALL return to ARB, and clear_done SHALL be 1 in the first ARB cycle.
REQ-026 In CLEAR, busy SHALL be 1, both readys SHALL be 0, and clear_start SHALL be ignored.
REQ-027 In CLEAR, requester valids SHALL be tolerated without loss; requesters hold their requests until ready.

Reset
REQ-028 Reset SHALL immediately set RegWrite, WriteRegister, WriteData, busy, clear_done, dropped, and the counter to 0, and set last-grant to B.
REQ-029 Reset asserted mid-CLEAR SHALL abort the sequence with no clear_done pulse; after release the FSM SHALL be in ARB.
REQ-030 The first handshake SHALL be possible at the first rising edge after reset deasserts.

Structure
REQ-031 Package regfile_pkg SHALL hold DATA_W, ADDR_W, ZERO_REG=31, NUM_CLEAR=31, and the state enum {ARB, CLEAR}.
REQ-032 The two-way round-robin decision SHALL be a sub-module rr_arb2 (inputs: req[1:0], last; output: gnt[1:0]).

Verification
REQ-033 Test: A only, a_reg=5, a_data=124. Required: a_ready=1; next cycle RegWrite=1, WriteRegister=5, WriteData=124.
REQ-034 Test: A and B valid together for 4 cycles (regs 1/2, different data). Required: grants A, B, A, B; one write per cycle; no write lost.
REQ-035 Test: B writes reg 31 with data -14. Required: b_ready=1; next cycle RegWrite=0 and dropped=1.
REQ-036 Test: clear_start pulse while A is valid. Required: a_ready=0; busy for 31 cycles writing 0 to regs 0..30; clear_done=1 once; then A is accepted.
REQ-037 Test: reset asserted at clear count 10. Required: outputs 0 immediately; no clear_done; ARB after release.
REQ-038 Test: integrated with the register file, write 207 to X28 and then read port 1 sel 28. Required: ReadData1=207 two edges after the handshake.
